// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the multicycle RV32 core: controller state
// encodings, major opcodes, ALU operand/operation select codes, trap causes,
// and the bundle of per-state datapath control lines.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

    // Controller states; the numeric values are visible on the debug port.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    // Major opcodes (IR[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALU A input select
    localparam logic [1:0] ALU_A_PC     = 2'b00;
    localparam logic [1:0] ALU_A_OLD_PC = 2'b01;
    localparam logic [1:0] ALU_A_RS1    = 2'b10;

    // ALU B input select
    localparam logic [1:0] ALU_B_RS2  = 2'b00;
    localparam logic [1:0] ALU_B_FOUR = 2'b01;
    localparam logic [1:0] ALU_B_IMM  = 2'b10;

    // ALU operation class, decoded further by the ALU decoder
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // All control lines the controller drives, so one '0 clears them at once.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       retire;
        logic       trap;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Shared-memory request/acknowledge bundle between the controller and memory.
//   mem_req   : access request (controller -> memory)
//   mem_we    : write strobe, valid with mem_req
//   i_or_d    : address select, 0 = PC, 1 = ALUOut
//   mem_ready : acknowledge (memory -> controller)
// Modports: master = controller side, slave = memory side.
// -----------------------------------------------------------------------------
interface multicycle_control_if;

    logic mem_req;
    logic mem_we;
    logic i_or_d;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output i_or_d,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  i_or_d,
        output mem_ready
    );

endinterface

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts unacknowledged memory-request cycles and flags when the current
// cycle is the last one allowed before a timeout.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the count (state change)
//   count_en : request pending and not acknowledged this cycle
//   limit    : maximum unacknowledged cycles; 0 disables the timeout
//   expired  : the count has reached limit-1
// -----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         count_en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: combinational blocks assign every output a default first so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flag the limit-th waiting cycle itself, so a ready in that same cycle
    // can still win over the timeout.
    assign expired = (limit != '0) && (cnt_q == limit - W'(1));

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// State sequencer for the multicycle RV32 core. Drives memory, register
// file, ALU and PC-mux controls per state, holds memory accesses until
// acknowledged, traps on illegal opcodes and memory timeouts, and keeps
// cycle / retired-instruction counters.
//   clk, rst      : clock, synchronous active-high reset
//   opcode        : IR[6:0], valid from DECODE onward
//   mem           : memory handshake (master modport)
//   ir_write      : load IR and old_pc
//   pc_write      : unconditional PC load
//   pc_write_cond : PC load if ALU zero
//   pc_src        : 0 = ALU result, 1 = ALUOut
//   alu_src_a/b   : ALU operand selects
//   alu_op        : ALU operation class
//   reg_write     : register write enable
//   mem_to_reg    : write-back source, 0 = ALUOut, 1 = MDR
//   retire        : one-cycle pulse in the last state of an instruction
//   trap, cause   : trap flag and held cause
//   state         : current state (debug)
//   cycle_cnt     : cycles since reset
//   instret_cnt   : instructions retired since reset
// -----------------------------------------------------------------------------
module multicycle_control
    import riscv_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    multicycle_control_if.master mem,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 pc_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 retire,
    output logic                 trap,
    output logic [1:0]           cause,
    output logic [3:0]           state,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instret_cnt
);

    localparam int TMR_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       cause_q;
    logic [1:0]       cause_d;
    ctrl_t            ctrl;
    ctrl_t            ctrl_out;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;
    logic             timer_expired;
    logic             timer_clear;
    logic             timer_en;

    mem_wait_timer #(
        .W (TMR_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .count_en (timer_en),
        .limit    (TMR_W'(WAIT_MAX)),
        .expired  (timer_expired)
    );

    // Next-state and control decode. Controls are Moore except ir_write /
    // pc_write in FETCH and retire in MEM_WR, which follow mem_ready.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        ctrl    = '0;

        unique case (state_q)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_a = ALU_A_PC;
                ctrl.alu_src_b = ALU_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.ir_write  = mem.mem_ready;
                ctrl.pc_write  = mem.mem_ready;
                if (mem.mem_ready) begin
                    state_d = S_DECODE;
                end else if (timer_expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            S_DECODE: begin
                // Branch target old_pc + imm is parked in ALUOut here.
                ctrl.alu_src_a = ALU_A_OLD_PC;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
                case (opcode)
                    OPC_OP:               state_d = S_EXEC_R;
                    OPC_OP_IMM:           state_d = S_EXEC_I;
                    OPC_LOAD, OPC_STORE:  state_d = S_MEM_ADDR;
                    OPC_BRANCH:           state_d = S_BRANCH;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end

            S_EXEC_R: begin
                ctrl.alu_src_a = ALU_A_RS1;
                ctrl.alu_src_b = ALU_B_RS2;
                ctrl.alu_op    = ALU_OP_RTYPE;
                state_d        = S_WB_ALU;
            end

            S_EXEC_I: begin
                ctrl.alu_src_a = ALU_A_RS1;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
                state_d        = S_WB_ALU;
            end

            S_MEM_ADDR: begin
                ctrl.alu_src_a = ALU_A_RS1;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
                state_d        = (opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                ctrl.mem_req = 1'b1;
                ctrl.i_or_d  = 1'b1;
                if (mem.mem_ready) begin
                    state_d = S_WB_MEM;
                end else if (timer_expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            S_MEM_WR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.i_or_d  = 1'b1;
                ctrl.retire  = mem.mem_ready;
                if (mem.mem_ready) begin
                    state_d = S_FETCH;
                end else if (timer_expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            S_WB_ALU: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.retire     = 1'b1;
                state_d         = S_FETCH;
            end

            S_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
                state_d         = S_FETCH;
            end

            S_BRANCH: begin
                ctrl.alu_src_a     = ALU_A_RS1;
                ctrl.alu_src_b     = ALU_B_RS2;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = 1'b1;
                ctrl.retire        = 1'b1;
                state_d            = S_FETCH;
            end

            S_TRAP: begin
                // Sticky until reset; cause_q simply holds.
                ctrl.trap = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // The wait count covers one request only, so any state change restarts it.
    assign timer_en    = ctrl.mem_req & ~mem.mem_ready;
    assign timer_clear = (state_d != state_q);

    // While reset is sampled, drop every control line so an in-flight request
    // (or write strobe) is withdrawn for that cycle.
    assign ctrl_out = rst ? '0 : ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cause_q   <= CAUSE_NONE;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            cycle_q   <= cycle_q + CNT_W'(1);
            instret_q <= instret_q + CNT_W'(ctrl.retire);
        end
    end

    assign mem.mem_req   = ctrl_out.mem_req;
    assign mem.mem_we    = ctrl_out.mem_we;
    assign mem.i_or_d    = ctrl_out.i_or_d;
    assign ir_write      = ctrl_out.ir_write;
    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign pc_src        = ctrl_out.pc_src;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_op        = ctrl_out.alu_op;
    assign reg_write     = ctrl_out.reg_write;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign retire        = ctrl_out.retire;
    assign trap          = ctrl_out.trap;
    assign cause         = cause_q;
    assign state         = state_q;
    assign cycle_cnt     = cycle_q;
    assign instret_cnt   = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench for multicycle_control (CNT_W=4, WAIT_MAX=4). Each step
// pushes the expected per-cycle control vector (with the mem_ready/opcode
// to apply) onto a scoreboard queue; run() pops and compares cycle by cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int CW = 4;
    localparam int WM = 4;

    // Expected encodings, written independently of the design package.
    localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1, ST_EXEC_R = 4'd2,
                           ST_EXEC_I = 4'd3, ST_MEM_ADDR = 4'd4, ST_MEM_RD = 4'd5,
                           ST_MEM_WR = 4'd6, ST_WB_ALU = 4'd7, ST_WB_MEM = 4'd8,
                           ST_BRANCH = 4'd9, ST_TRAP = 4'd10;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                           OP_SW = 7'b0100011, OP_BEQ = 7'b1100011, OP_BAD = 7'b1111111;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_src;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       retire;
        logic       trap;
        logic [1:0] cause;
    } obs_t;

    typedef struct {
        obs_t       exp;
        logic       rdy;
        logic [6:0] opc;
    } item_t;

    logic          clk;
    logic          rst;
    logic [6:0]    opcode;
    logic          ir_write, pc_write, pc_write_cond, pc_src;
    logic [1:0]    alu_src_a, alu_src_b, alu_op;
    logic          reg_write, mem_to_reg, retire, trap;
    logic [1:0]    cause;
    logic [3:0]    state;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    multicycle_control_if intf ();

    multicycle_control #(
        .CNT_W    (CW),
        .WAIT_MAX (WM)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem           (intf),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .retire        (retire),
        .trap          (trap),
        .cause         (cause),
        .state         (state),
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
    );

    obs_t obs;
    assign obs = {state, intf.mem_req, intf.mem_we, intf.i_or_d, ir_write, pc_write,
                  pc_write_cond, pc_src, alu_src_a, alu_src_b, alu_op,
                  reg_write, mem_to_reg, retire, trap, cause};

    item_t sb[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    int    exp_cyc  = 0;
    int    exp_ret  = 0;
    int    step     = 0;
    string cur_test = "init";

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected controls for one cycle, straight from the state table.
    function automatic obs_t spec_out(logic [3:0] s, logic rdy, logic [1:0] c);
        obs_t o;
        o    = '0;
        o.st = s;
        case (s)
            ST_FETCH:    begin o.mem_req = 1'b1; o.b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            ST_DECODE:   begin o.a = 2'b01; o.b = 2'b10; end
            ST_EXEC_R:   begin o.a = 2'b10; o.b = 2'b00; o.op = 2'b10; end
            ST_EXEC_I:   begin o.a = 2'b10; o.b = 2'b10; end
            ST_MEM_ADDR: begin o.a = 2'b10; o.b = 2'b10; end
            ST_MEM_RD:   begin o.mem_req = 1'b1; o.i_or_d = 1'b1; end
            ST_MEM_WR:   begin o.mem_req = 1'b1; o.mem_we = 1'b1; o.i_or_d = 1'b1; o.retire = rdy; end
            ST_WB_ALU:   begin o.reg_write = 1'b1; o.retire = 1'b1; end
            ST_WB_MEM:   begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.retire = 1'b1; end
            ST_BRANCH:   begin o.a = 2'b10; o.op = 2'b01; o.pc_write_cond = 1'b1;
                               o.pc_src = 1'b1; o.retire = 1'b1; end
            ST_TRAP:     begin o.trap = 1'b1; o.cause = c; end
            default:     o = '1;
        endcase
        return o;
    endfunction

    task automatic push(input logic [3:0] s, input logic rdy, input logic [6:0] opc,
                        input logic [1:0] c = 2'b00);
        item_t it;
        it.exp = spec_out(s, rdy, c);
        it.rdy = rdy;
        it.opc = opc;
        sb.push_back(it);
    endtask

    task automatic push_beq();
        push(ST_FETCH, 1'b1, OP_BEQ);
        push(ST_DECODE, 1'b1, OP_BEQ);
        push(ST_BRANCH, 1'b1, OP_BEQ);
    endtask

    // Drain the scoreboard: apply inputs, compare mid-cycle, advance a clock.
    task automatic run();
        item_t it;
        while (sb.size() > 0) begin
            it             = sb.pop_front();
            intf.mem_ready = it.rdy;
            opcode         = it.opc;
            #2;
            n_assert++;
            assert (obs === it.exp) else begin
                n_fail++;
                $error("FAIL %s step %0d: observed %h expected %h", cur_test, step, obs, it.exp);
            end
            step++;
            if (it.exp.retire) exp_ret++;
            exp_cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_cnt();
        n_assert++;
        assert (cycle_cnt === CW'(exp_cyc)) else begin
            n_fail++;
            $error("FAIL %s cycle_cnt: observed %0d expected %0d", cur_test, cycle_cnt, CW'(exp_cyc));
        end
        n_assert++;
        assert (instret_cnt === CW'(exp_ret)) else begin
            n_fail++;
            $error("FAIL %s instret_cnt: observed %0d expected %0d", cur_test, instret_cnt, CW'(exp_ret));
        end
    endtask

    // Reset for one edge: request lines must drop while rst is high, and the
    // next cycle shows the documented reset values.
    task automatic do_reset();
        rst            = 1'b1;
        intf.mem_ready = 1'b0;
        #1;
        n_assert++;
        assert ({intf.mem_req, intf.mem_we} === 2'b00) else begin
            n_fail++;
            $error("FAIL %s req_during_rst: observed %b expected 00", cur_test, {intf.mem_req, intf.mem_we});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        exp_cyc = 0;
        exp_ret = 0;
        n_assert++;
        assert (obs === spec_out(ST_FETCH, 1'b0, 2'b00)) else begin
            n_fail++;
            $error("FAIL %s reset_outputs: observed %h expected %h", cur_test, obs, spec_out(ST_FETCH, 1'b0, 2'b00));
        end
        check_cnt();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, required finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        opcode         = 7'd0;
        intf.mem_ready = 1'b0;

        cur_test = "reset";
        do_reset();

        // R-type, zero-wait: 4 cycles, instret=1 on cycle 5
        cur_test = "rtype";
        push(ST_FETCH, 1'b1, OP_R);
        push(ST_DECODE, 1'b1, OP_R);
        push(ST_EXEC_R, 1'b1, OP_R);
        push(ST_WB_ALU, 1'b1, OP_R);
        run();
        check_cnt();

        // lw with 3 wait cycles in MEM_RD: 8 cycles
        cur_test = "lw_wait";
        push(ST_FETCH, 1'b1, OP_LW);
        push(ST_DECODE, 1'b1, OP_LW);
        push(ST_MEM_ADDR, 1'b1, OP_LW);
        for (int i = 0; i < 3; i++) push(ST_MEM_RD, 1'b0, OP_LW);
        push(ST_MEM_RD, 1'b1, OP_LW);
        push(ST_WB_MEM, 1'b1, OP_LW);
        run();
        check_cnt();

        // addi, then sw with two wait cycles (retire on the acknowledge)
        cur_test = "addi_sw";
        push(ST_FETCH, 1'b1, OP_I);
        push(ST_DECODE, 1'b1, OP_I);
        push(ST_EXEC_I, 1'b1, OP_I);
        push(ST_WB_ALU, 1'b1, OP_I);
        push(ST_FETCH, 1'b1, OP_SW);
        push(ST_DECODE, 1'b1, OP_SW);
        push(ST_MEM_ADDR, 1'b1, OP_SW);
        push(ST_MEM_WR, 1'b0, OP_SW);
        push(ST_MEM_WR, 1'b0, OP_SW);
        push(ST_MEM_WR, 1'b1, OP_SW);
        run();
        check_cnt();

        // Ready on the 4th fetch cycle beats the timeout, then beq
        cur_test = "fetch_ready_last";
        for (int i = 0; i < 3; i++) push(ST_FETCH, 1'b0, OP_BEQ);
        push(ST_FETCH, 1'b1, OP_BEQ);
        push(ST_DECODE, 1'b1, OP_BEQ);
        push(ST_BRANCH, 1'b1, OP_BEQ);
        run();
        check_cnt();

        // Reset while a store is waiting
        cur_test = "rst_mid_wr";
        push(ST_FETCH, 1'b1, OP_SW);
        push(ST_DECODE, 1'b1, OP_SW);
        push(ST_MEM_ADDR, 1'b1, OP_SW);
        push(ST_MEM_WR, 1'b0, OP_SW);
        push(ST_MEM_WR, 1'b0, OP_SW);
        run();
        do_reset();

        // 16 back-to-back beq: instret wraps 15 -> 0
        cur_test = "wrap15";
        for (int i = 0; i < 15; i++) push_beq();
        run();
        check_cnt();
        cur_test = "wrap16";
        push_beq();
        run();
        check_cnt();

        // Illegal opcode: trap, cause 01, held for 100 cycles
        cur_test = "illegal";
        push(ST_FETCH, 1'b1, OP_BAD);
        push(ST_DECODE, 1'b1, OP_BAD);
        for (int i = 0; i < 100; i++) push(ST_TRAP, i[0], OP_BAD, 2'b01);
        run();
        check_cnt();
        do_reset();

        // Fetch never acknowledged: trap after exactly 4 request cycles
        cur_test = "timeout";
        for (int i = 0; i < WM; i++) push(ST_FETCH, 1'b0, OP_R);
        for (int i = 0; i < 3; i++) push(ST_TRAP, 1'b1, OP_R, 2'b10);
        run();
        check_cnt();
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
